// File: rtl/configurable_serial_comparator.sv
// Wide-operand comparator, CHUNK bits per cycle MS chunk first; CONFIGURABLE_SERIAL_COMPARATOR_EARLY_EXIT_EN stops at the first differing chunk.
// Latency NUM_CHUNKS cycles from accept to out_valid (1..NUM_CHUNKS with early exit).
// Backpressure: results held while out_valid && !out_ready; in_ready only in IDLE.
module configurable_serial_comparator #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op_sel,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             result,
   output logic             out_eq,
   output logic             out_lt,
   output logic             busy
);

   localparam int NUM_CHUNKS = WIDTH / CHUNK;
   localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_op;
   logic             r_signed;
   logic [IDX_W-1:0] r_idx;
   logic             r_decided;
   logic             r_lt;
   logic             r_result;
   logic             r_out_eq;
   logic             r_out_lt;

   logic             w_accept;
   logic [CHUNK-1:0] w_chunk_a;
   logic [CHUNK-1:0] w_chunk_b;
   logic             w_differ;
   logic             w_first;
   logic             w_last;
   logic             w_chunk_lt;
   logic             w_decide_now;
   logic             w_dec_nxt;
   logic             w_lt_nxt;
   logic             w_finish;

   function automatic logic f_select(input logic [2:0] op, input logic eq, input logic lt);
      logic res;
      res = 1'b0;
      case (op)
         3'b000:  res = eq;
         3'b001:  res = !eq;
         3'b010:  res = lt;
         3'b011:  res = lt | eq;
         3'b100:  res = !lt & !eq;
         3'b101:  res = !lt;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   assign w_accept  = in_valid && in_ready;

   // Operands shift left each cycle, so the chunk under test is always the top slice.
   assign w_chunk_a = r_a[WIDTH-1 -: CHUNK];
   assign w_chunk_b = r_b[WIDTH-1 -: CHUNK];
   assign w_differ  = (w_chunk_a != w_chunk_b);
   assign w_first   = (r_idx == LAST_IDX);
   assign w_last    = (r_idx == '0);

   assign w_chunk_lt   = (w_first && r_signed) ? ($signed(w_chunk_a) < $signed(w_chunk_b))
                                               : (w_chunk_a < w_chunk_b);
   assign w_decide_now = !r_decided && w_differ;
   assign w_dec_nxt    = r_decided | w_differ;
   assign w_lt_nxt     = w_decide_now ? w_chunk_lt : r_lt;

`ifdef CONFIGURABLE_SERIAL_COMPARATOR_EARLY_EXIT_EN
   assign w_finish = w_last || w_decide_now;
`else
   assign w_finish = w_last;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (w_accept)  w_state_nxt = S_COMPARE;
         S_COMPARE: if (w_finish)  w_state_nxt = S_DONE;
         S_DONE:    if (out_ready) w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a       <= '0;
         r_b       <= '0;
         r_op      <= '0;
         r_signed  <= 1'b0;
         r_idx     <= '0;
         r_decided <= 1'b0;
         r_lt      <= 1'b0;
         r_result  <= 1'b0;
         r_out_eq  <= 1'b0;
         r_out_lt  <= 1'b0;
      end else if (w_accept) begin
         r_a       <= a;
         r_b       <= b;
         r_op      <= op_sel;
         r_signed  <= signed_mode;
         r_idx     <= LAST_IDX;
         r_decided <= 1'b0;
         r_lt      <= 1'b0;
      end else if (r_state == S_COMPARE) begin
         r_a       <= r_a << CHUNK;
         r_b       <= r_b << CHUNK;
         r_idx     <= r_idx - 1'b1;
         r_decided <= w_dec_nxt;
         r_lt      <= w_lt_nxt;
         if (w_finish) begin
            r_out_eq <= !w_dec_nxt;
            r_out_lt <= w_lt_nxt;
            r_result <= f_select(r_op, !w_dec_nxt, w_lt_nxt);
         end
      end
   end

   assign in_ready  = (r_state == S_IDLE) && !rst;
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign result    = r_result;
   assign out_eq    = r_out_eq;
   assign out_lt    = r_out_lt;

endmodule
